// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory behind a fixed-latency request/response port.
// Performs RISC-V style LB/LH/LW/LBU/LHU loads and SB/SH/SW stores, flagging misaligned/illegal ops.
module data_mem_ctrl #(
    parameter int    ADDRESS_WIDTH = 18,
    parameter int    DATA_WIDTH    = 32,
    parameter int    LATENCY       = 2,
    parameter string INIT_FILE     = "",
    parameter int    INIT_BASE     = 'h10000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_ctrl,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                   r_state, w_next;
    logic [3:0]               r_cnt;
    logic                     r_we;
    logic [2:0]               r_ctrl;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_err;
    logic [7:0]               r_mem [0:DEPTH-1];

    logic                     w_accept, w_enter_resp, w_mem_we, w_err;
    logic                     w_op_we;
    logic [2:0]               w_op_ctrl;
    logic [ADDRESS_WIDTH-1:0] w_op_addr, w_a1, w_a2, w_a3;
    logic [DATA_WIDTH-1:0]    w_op_wdata, w_rdata;
    logic [7:0]               w_b0, w_b1, w_b2, w_b3;

    assign req_ready    = (r_state == S_IDLE) && !rst;
    assign resp_valid   = (r_state == S_RESP);
    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // With LATENCY=1 the memory op happens on the accept edge, before the fields are latched.
    assign w_op_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_op_ctrl  = (r_state == S_IDLE) ? req_ctrl  : r_ctrl;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_a1 = w_op_addr + ADDRESS_WIDTH'(1);
    assign w_a2 = w_op_addr + ADDRESS_WIDTH'(2);
    assign w_a3 = w_op_addr + ADDRESS_WIDTH'(3);
    assign w_b0 = r_mem[w_op_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    assign w_mem_we = w_enter_resp && w_op_we && !w_err && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_err = 1'b0;
        if (w_op_we) begin
            case (w_op_ctrl)
                3'b000:  w_err = 1'b0;
                3'b001:  w_err = w_op_addr[0];
                3'b010:  w_err = |w_op_addr[1:0];
                default: w_err = 1'b1;
            endcase
        end else begin
            case (w_op_ctrl)
                3'b000, 3'b100: w_err = 1'b0;
                3'b001, 3'b101: w_err = w_op_addr[0];
                3'b010:         w_err = |w_op_addr[1:0];
                default:        w_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_op_ctrl)
            3'b000:  w_rdata = {{24{w_b0[7]}}, w_b0};
            3'b100:  w_rdata = {24'd0, w_b0};
            3'b001:  w_rdata = {{16{w_b1[7]}}, w_b1, w_b0};
            3'b101:  w_rdata = {16'd0, w_b1, w_b0};
            3'b010:  w_rdata = {w_b3, w_b2, w_b1, w_b0};
            default: w_rdata = '0;
        endcase
        if (w_op_we || w_err) w_rdata = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_ctrl  <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_we    <= req_we;
                r_ctrl  <= req_ctrl;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_rdata;
                r_err   <= w_err;
            end
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_op_addr] <= w_op_wdata[7:0];
            if (w_op_ctrl != 3'b000) r_mem[w_a1] <= w_op_wdata[15:8];
            if (w_op_ctrl == 3'b010) begin
                r_mem[w_a2] <= w_op_wdata[23:16];
                r_mem[w_a3] <= w_op_wdata[31:24];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl at default parameters (LATENCY=2).
// Expected responses are queued at request accept and compared when resp_valid is seen.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_ctrl;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] q_rdata[$];
    logic        q_err[$];
    int          q_cyc[$];
    string       q_tag[$];

    data_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] er, input logic ee);
        q_tag.push_back(tag);
        q_rdata.push_back(er);
        q_err.push_back(ee);
        q_cyc.push_back(cyc);
    endtask

    // Leaves the bench at a negedge with req_ready high, or reports a timeout.
    task automatic wait_ready(input string tag, output logic ok);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = req_ready;
        if (!ok) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] ctrl,
                          input logic [17:0] addr, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee);
        logic ok;
        wait_ready(tag, ok);
        if (ok) begin
            req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wd;
            push_exp(tag, er, ee);
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (q_tag.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                string       t;
                logic [31:0] er;
                logic        ee;
                int          c;
                t = q_tag.pop_front(); er = q_rdata.pop_front();
                ee = q_err.pop_front(); c = q_cyc.pop_front();
                chk({t, "_rdata"}, resp_rdata, er);
                chk({t, "_err"}, {31'd0, resp_err}, {31'd0, ee});
                chk({t, "_lat"}, cyc - c, 32'd2);
            end
        end
    end

    initial begin
        logic ok;
        int   acc[$];
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_ctrl = 3'd0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;

        do_req("sw100",  1, 3'b010, 18'h100, 32'hDEADBEEF, 32'h0, 0);
        do_req("lw100",  0, 3'b010, 18'h100, 32'h0, 32'hDEADBEEF, 0);
        do_req("lb103",  0, 3'b000, 18'h103, 32'h0, 32'hFFFFFFDE, 0);
        do_req("lbu103", 0, 3'b100, 18'h103, 32'h0, 32'h000000DE, 0);
        do_req("lh100",  0, 3'b001, 18'h100, 32'h0, 32'hFFFFBEEF, 0);
        do_req("lhu102", 0, 3'b101, 18'h102, 32'h0, 32'h0000DEAD, 0);
        do_req("lbu100", 0, 3'b100, 18'h100, 32'h0, 32'h000000EF, 0);
        do_req("sb101",  1, 3'b000, 18'h101, 32'h000000AA, 32'h0, 0);
        do_req("lw_sb",  0, 3'b010, 18'h100, 32'h0, 32'hDEADAAEF, 0);
        do_req("sw102e", 1, 3'b010, 18'h102, 32'h11111111, 32'h0, 1);
        do_req("lw_nochg", 0, 3'b010, 18'h100, 32'h0, 32'hDEADAAEF, 0);
        do_req("lh101e", 0, 3'b001, 18'h101, 32'h0, 32'h0, 1);
        do_req("ld011e", 0, 3'b011, 18'h100, 32'h0, 32'h0, 1);
        do_req("st011e", 1, 3'b011, 18'h100, 32'h22222222, 32'h0, 1);
        do_req("sh102",  1, 3'b001, 18'h102, 32'h99991234, 32'h0, 0);
        do_req("lw_sh",  0, 3'b010, 18'h100, 32'h0, 32'h1234AAEF, 0);
        do_req("sw_top", 1, 3'b010, 18'h3FFFC, 32'h8765CAFE, 32'h0, 0);
        do_req("lh_top", 0, 3'b001, 18'h3FFFE, 32'h0, 32'hFFFF8765, 0);
        do_req("lb_top", 0, 3'b000, 18'h3FFFC, 32'h0, 32'hFFFFFFFE, 0);

        // Back-to-back: req_valid held high across two accepts.
        wait_ready("b2b", ok);
        req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b010; req_addr = 18'h100; req_wdata = '0;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) @(negedge clk);
            chk("b2b_ready", {31'd0, req_ready}, (n % 3 == 0) ? 32'd1 : 32'd0);
            if (req_ready) begin
                push_exp("b2b", 32'h1234AAEF, 0);
                acc.push_back(cyc);
            end
        end
        req_valid = 1'b0;
        if (acc.size() == 2) chk("b2b_spacing", acc[1] - acc[0], 32'd3);
        else chk("b2b_accepts", acc.size(), 32'd2);

        // Reset while a store is in flight drops it.
        do_req("sw200",  1, 3'b010, 18'h200, 32'hCAFEF00D, 32'h0, 0);
        wait_ready("sw_drop", ok);
        if (ok) begin
            req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010; req_addr = 18'h200;
            req_wdata = 32'h12345678;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            #1 chk("drop_ready_in_rst", {31'd0, req_ready}, 32'd0);
            repeat (2) @(negedge clk);
            chk("drop_no_resp", {31'd0, resp_valid}, 32'd0);
            rst = 1'b0;
        end
        do_req("lw200",  0, 3'b010, 18'h200, 32'h0, 32'hCAFEF00D, 0);

        for (int t = 0; t < 50 && q_tag.size() != 0; t++) @(negedge clk);
        if (q_tag.size() != 0) chk("drain_timeout", q_tag.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 18, byte-address width; memory depth 2**ADDRESS_WIDTH bytes.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, request/response data width; only 32 is legal.
REQ-003 SHALL have parameter LATENCY, default 2, range 1..15, cycles from request accept to response.
REQ-004 SHALL have parameter INIT_FILE, default "", hex image loaded at INIT_BASE when non-empty.
REQ-005 SHALL have parameter INIT_BASE, default 'h10000, byte offset for INIT_FILE load.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port req_valid  input  1  request present.
REQ-009 SHALL have port req_ready  output  1  block can accept a request.
REQ-010 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port req_ctrl  input  3  RISC-V funct3 access size/sign.
REQ-012 SHALL have port req_addr  input  ADDRESS_WIDTH  byte address.
REQ-013 SHALL have port req_wdata  input  DATA_WIDTH  store data, low bytes used for SB/SH.
REQ-014 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-015 SHALL have port resp_rdata  output  DATA_WIDTH  load result, extended.
REQ-016 SHALL have port resp_err  output  1  request was misaligned or illegal; valid with resp_valid.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE and not in reset.
REQ-018 SHALL accept a request on a rising edge with req_valid & req_ready, latching we, ctrl, addr, wdata; inputs ignored otherwise.
REQ-019 SHALL on accept go to WAIT with a down-counter loaded to LATENCY-1, or directly to RESP when LATENCY = 1.
REQ-020 SHALL in WAIT decrement the counter each cycle and go to RESP on the edge where it is 1 → 0 transition completes.
REQ-021 SHALL assert resp_valid exactly LATENCY cycles after the accept edge, for one cycle, then return to IDLE; throughput one request per LATENCY+1 cycles.
REQ-022 SHALL perform memory read/write on the edge entering RESP, from latched fields; resp_rdata/resp_err registered on that edge and held until next response.
REQ-023 SHALL store little-endian: byte at addr holds bits [7:0].
REQ-024 SHALL decode loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-025 SHALL decode stores: 000 SB writes 1 byte, 001 SH writes 2 bytes, 010 SW writes 4 bytes; untouched bytes unchanged.
REQ-026 SHALL flag resp_err=1 for halfword with addr[0]=1, word with addr[1:0]≠0, store ctrl not in {000,001,010}, load ctrl in {011,110,111}.
REQ-027 SHALL on an error response perform no write and return resp_rdata = 0.
REQ-028 SHALL never wrap within an aligned access; aligned accesses cannot exceed the top address.
REQ-029 SHALL return resp_rdata = 0 for store responses with resp_err = 0.

Reset
REQ-030 SHALL on rst asynchronously force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0 while rst high.
REQ-031 SHALL drop an in-flight request if rst asserts before the RESP edge: no write occurs, no response issued.
REQ-032 SHALL NOT clear memory contents on reset; INIT_FILE load occurs at simulation start only.

Verification
REQ-033 SHALL cover: LATENCY=2, SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: memory 0x100=0xDEADBEEF; LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x100 -> 0xFFFFBEEF; LHU 0x102 -> 0x0000DEAD.
REQ-035 SHALL cover: SB 0x101 data 0x000000AA over 0xDEADBEEF, then LW 0x100 -> 0xDEADAAEF.
REQ-036 SHALL cover: SW 0x102 -> err 1, rdata 0, memory unchanged; LH 0x101 -> err 1; load ctrl 011 -> err 1.
REQ-037 SHALL cover: req_valid held high continuously -> req_ready low during WAIT/RESP, second request accepted only back in IDLE, 3-cycle spacing at LATENCY=2.
REQ-038 SHALL cover: accept SW 0x200 data 0x12345678, assert rst one cycle later -> no resp_valid, subsequent LW 0x200 returns prior contents.
